// File: rtl/asynchronous_fifo_if.sv
// Handshake and status bundle between a producer/consumer (master) and the FIFO (slave).
interface asynchronous_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_enb;
  logic                  rd_enb;
  logic [DATA_WIDTH-1:0] input_data;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  full;
  logic                  almost_full;
  logic                  half_full;
  logic                  almost_empty;
  logic                  empty;

  modport master (
    output wr_enb, rd_enb, input_data,
    input  output_data, full, almost_full, half_full, almost_empty, empty
  );

  modport slave (
    input  wr_enb, rd_enb, input_data,
    output output_data, full, almost_full, half_full, almost_empty, empty
  );
endinterface

// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and fill-level flags.
module asynchronous_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               wr_clk,
  input  logic               rstn,
  asynchronous_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH:0] LVL_HALF = (ADDR_WIDTH+1)'(DEPTH/2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  empty_c;
  logic                  full_c;
  logic                  wr_acc_p0;
  logic                  rd_acc_p0;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // The wrap bit makes full and empty distinguishable when the address bits match.
  assign level   = wr_ptr - rd_ptr;
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_acc_p0 = bus.wr_enb && !full_c;
  assign rd_acc_p0 = bus.rd_enb && !empty_c;

  // Stage p0 -> p1: storage write, pointer advance and registered read data.
  always_ff @(posedge wr_clk) begin
    if (wr_acc_p0) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.input_data;
    end
  end

  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_data_p1 <= '0;
    end else begin
      if (wr_acc_p0) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc_p0) begin
        rd_data_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr     <= rd_ptr + 1'b1;
      end
    end
  end

  assign bus.output_data  = rd_data_p1;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_full  = (level == LVL_AF);
  assign bus.half_full    = (level >= LVL_HALF);
  assign bus.almost_empty = (level == LVL_ONE);

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Randomised and directed bench for asynchronous_fifo against a queue-based reference model.
module tb_asynchronous_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic wr_clk;
  logic rstn;

  asynchronous_fifo_if #(.DATA_WIDTH(DW)) bus ();

  asynchronous_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .ADDR_WIDTH(AW)
  ) dut (
    .wr_clk(wr_clk),
    .rstn  (rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_out;
  int            wr_cnt;
  int            rd_cnt;

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [4:0] exp_flags;
    logic [4:0] got_flags;
    n = q.size();
    exp_flags = {n == DP, n == DP-1, n >= DP/2, n == 1, n == 0};
    got_flags = {bus.full, bus.almost_full, bus.half_full, bus.almost_empty, bus.empty};
    chk({tag, ".data"},   32'(bus.output_data), 32'(exp_out));
    chk({tag, ".flags"},  32'(got_flags),       32'(exp_flags));
    chk({tag, ".wr_ptr"}, 32'(dut.wr_ptr),      32'(wr_cnt % (2*DP)));
    chk({tag, ".rd_ptr"}, 32'(dut.rd_ptr),      32'(rd_cnt % (2*DP)));
  endtask

  task automatic model_reset();
    q.delete();
    exp_out = '0;
    wr_cnt  = 0;
    rd_cnt  = 0;
  endtask

  task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit wa;
    bit ra;
    bus.wr_enb     = w;
    bus.rd_enb     = r;
    bus.input_data = d;
    wa = w && (q.size() < DP);
    ra = r && (q.size() > 0);
    @(posedge wr_clk);
    if (ra) begin
      exp_out = q.pop_front();
      rd_cnt++;
    end
    if (wa) begin
      q.push_back(d);
      wr_cnt++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] d;
    rstn           = 1'b0;
    bus.wr_enb     = 1'b0;
    bus.rd_enb     = 1'b0;
    bus.input_data = '0;
    model_reset();
    repeat (2) @(posedge wr_clk);
    #1;
    check_all("reset");
    rstn = 1'b1;

    for (int i = 0; i < 3; i++) step("idle_rd", 1'b0, 1'b1, 8'h00);

    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, DW'(i));
    step("wr_full", 1'b1, 1'b0, 8'hFF);

    for (int i = 0; i < 17; i++) step("drain", 1'b0, 1'b1, 8'h00);

    d = 8'hA0;
    for (int i = 0; i < 10; i++) begin step("wrap_w10", 1'b1, 1'b0, d); d++; end
    for (int i = 0; i < 10; i++) step("wrap_r10", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) begin step("wrap_w12", 1'b1, 1'b0, d); d++; end
    for (int i = 0; i < 12; i++) step("wrap_r12", 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, DW'(8'h30 + i));
    for (int i = 0; i < 4; i++) step("both_mid", 1'b1, 1'b1, DW'(8'h40 + i));
    for (int i = 0; i < 11; i++) step("to_full", 1'b1, 1'b0, DW'(8'h50 + i));
    for (int i = 0; i < 4; i++) step("both_full", 1'b1, 1'b1, DW'(8'h60 + i));
    while (q.size() > 0) step("to_empty", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step("both_empty", 1'b1, 1'b1, DW'(8'h70 + i));
    while (q.size() > 0) step("clear", 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 7; i++) step("pre7", 1'b1, 1'b0, DW'(8'h80 + i));
    bus.wr_enb = 1'b0;
    bus.rd_enb = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge wr_clk);
    #1;
    check_all("rst_hold");
    rstn = 1'b1;
    step("post_rst_w", 1'b1, 1'b0, 8'h5A);
    step("post_rst_r", 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), DW'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      step("rand_drain", 1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 70), DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
